axi2ram: RTL and testbench
==========================

Name: axi2ram

Overview:
- AXI3 slave (responder) that terminates the AXI master port of the tawas core directly onto a single-port synchronous RAM.
- Provides a short direct path with no Spartan bridge: tawas AXI -> axi2ram -> 64-bit RAM.
- Supports FIXED and INCR bursts of 1-16 beats, 64-bit data and 2-bit IDs.
- Handles one transaction at a time; writes and reads are arbitrated alternately.

Parameters:
- ID_WIDTH, 2, width of AWID/WID/BID/ARID/RID.
- BWIDTH, 64, data width in bits; BWIDTH/8 strobe bits; address step per INCR beat = BWIDTH/8.
- ADDR_MASK, 32'h00000000, address bits forced to zero before driving ADDR; 0 = pass-through.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWVALID  in  2/32/4/3/2/2/4/3/1  AXI3 write address channel; LOCK/CACHE/PROT are ignored.
- AWREADY  out  1  write address accept.
- WID/WDATA/WSTRB/WLAST/WVALID  in  2/64/8/1/1  write data channel.
- WREADY  out  1  write data accept.
- BID/BRESP/BVALID  out  2/2/1  write response.
- BREADY  in  1  write response accept.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARVALID  in  as AW  read address channel.
- ARREADY  out  1  read address accept.
- RID/RDATA/RRESP/RLAST/RVALID  out  2/64/2/1/1  read data channel.
- RREADY  in  1  read data accept.
- CS  out  1  RAM select.
- WE  out  1  RAM write enable.
- ADDR  out  32  RAM byte address, low 3 bits zero.
- MASK  out  64  per-bit write mask: WSTRB[i] replicated over bits [8i+7:8i].
- WR_DATA  out  64  RAM write data.
- RD_DATA  in  64  RAM read data, valid the cycle after CS&&!WE is sampled.

Behaviour:
- Reset: every output is 0 (including RDATA, ADDR, MASK) and the FSM goes to IDLE. Reset mid-burst discards the transaction with no response.
- All outputs are registered.
- FSM states: IDLE, WDATA, WRESP, RADDR, RWAIT, RDATA.
- IDLE arbitration:
  - Only AWVALID -> write. Only ARVALID -> read.
  - Both valid -> the direction not served last; the "last" flag resets to read, so write wins the first tie.
  - AWREADY or ARREADY pulses for exactly one cycle on acceptance.
  - The request fields are captured; the address is aligned with ADDR & ~ADDR_MASK & ~7.
- Response code: SLVERR (2'b10) when AxSIZE != 3 or AxBURST == WRAP (2'b10); the burst then executes as INCR. Otherwise OKAY (2'b00).
- WDATA state:
  - WREADY = 1.
  - Each WVALID&&WREADY beat drives CS=1, WE=1, ADDR, MASK and WR_DATA in the next cycle.
  - The beat counter increments; INCR adds 8 to the address (32-bit wrap-around allowed), FIXED holds it.
  - WREADY drops after beat AWLEN+1.
  - WLAST disagreeing with the count, or WID != AWID, sets SLVERR. Beats are still written. The write ends on the count, not on WLAST.
- WRESP state: BVALID=1 with BID = captured ID and the BRESP held until BREADY; then IDLE. AWREADY stays 0 until BVALID&&BREADY.
- Read sequence per beat:
  - RADDR: CS=1, WE=0 for one cycle.
  - RWAIT: wait one cycle.
  - RDATA: RDATA <= RD_DATA; RVALID=1, RID, RRESP, and RLAST = (last beat); held stable until RREADY.
- Read latency: with the AR handshake at edge k, RVALID is high after edge k+3. Each subsequent beat's RVALID is high 3 edges after the previous R handshake.
- Address generation between read beats follows the same INCR/FIXED rule as writes.
- CS is never asserted in IDLE, WRESP or RWAIT. WE is never 1 during a read.
- Writes and reads never overlap; the RAM sees at most one access per cycle.

Decomposition:
- Package axi2ram_pkg:
  - burst encodings FIXED=0, INCR=1, WRAP=2;
  - response codes OKAY=0, SLVERR=2;
  - the FSM state enum;
  - beat-size constant 8.
- Sub-module axi2ram_addr_gen: loads the start address and length, steps by burst type, and flags the last beat. It is shared by the read and write paths.

Test Plan:
- Single write: AWADDR=32'h100, AWLEN=0, AWSIZE=3, INCR, WSTRB=8'h0F, WDATA=64'h1122334455667788 -> one cycle with CS=1, WE=1, ADDR=32'h100, MASK=64'h00000000FFFFFFFF; then BVALID with BRESP=0 and BID=AWID.
- INCR write burst: AWADDR=32'h200, AWLEN=3 -> ADDR sequence 200/208/210/218, then one B response. A FIXED burst with the same length -> ADDR stays 32'h200 for all four beats.
- Read burst: ARADDR=32'h200, ARLEN=3, RREADY=1 -> 4 beats, RLAST only on the 4th, RVALID 3 edges after each handshake. With RREADY low for 5 cycles on beat 2 -> RDATA/RVALID held stable and no extra CS.
- Simultaneous AWVALID and ARVALID after reset -> write served first, read next. Repeating the tie -> write again, since the last-served flag alternates.
- Error cases: AWSIZE=2 -> BRESP=2'b10. WLAST on beat 2 of AWLEN=3 -> all 4 beats written and BRESP=2'b10. ARBURST=WRAP -> RRESP=2'b10 on every beat.
- RST asserted during beat 2 of a read burst -> all outputs 0 within the same cycle. After release, a new single read completes normally.

Source files
------------

// File: rtl/axi2ram_pkg.sv
// Shared encodings, FSM states and the request-error rule for the axi2ram AXI3-to-RAM bridge.
package axi2ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam int unsigned BEAT_BYTES = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RWAIT = 3'd4,
    S_RDATA = 3'd5
  } state_e;

  // Anything other than a full-width beat, or a WRAP burst, is answered with SLVERR.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [2:0] full_size);
    return (size != full_size) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi2ram_addr_gen.sv
// Burst address generator shared by the read and write paths: holds the current beat
// address, steps it for INCR (FIXED holds) and flags the final beat of the burst.
module axi2ram_addr_gen
  import axi2ram_pkg::*;
#(
  parameter int unsigned STEP = BEAT_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  len_i,
  input  logic        fixed_i,
  output logic [31:0] addr_o,
  output logic        last_o
);

  localparam logic [31:0] STEP_W = 32'(STEP);

  logic [31:0] addr_q;
  logic [3:0]  cnt_q;
  logic [3:0]  len_q;
  logic        fixed_q;

  // Load on acceptance, advance one beat per step; the address wraps at 32 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= 32'd0;
      cnt_q   <= 4'd0;
      len_q   <= 4'd0;
      fixed_q <= 1'b0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      cnt_q   <= 4'd0;
      len_q   <= len_i;
      fixed_q <= fixed_i;
    end else if (step_i) begin
      addr_q  <= addr_q + (fixed_q ? 32'd0 : STEP_W);
      cnt_q   <= cnt_q + 4'd1;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/axi2ram.sv
// AXI3 slave terminating one transaction at a time onto a single-port synchronous RAM.
// Writes and reads alternate on ties; every output is a register.
module axi2ram
  import axi2ram_pkg::*;
#(
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned BWIDTH    = 64,
  parameter logic [31:0] ADDR_MASK = 32'h00000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [31:0]           AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ID_WIDTH-1:0]   WID,
  input  logic [BWIDTH-1:0]     WDATA,
  input  logic [BWIDTH/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [31:0]           ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [BWIDTH-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  CS,
  output logic                  WE,
  output logic [31:0]           ADDR,
  output logic [BWIDTH-1:0]     MASK,
  output logic [BWIDTH-1:0]     WR_DATA,
  input  logic [BWIDTH-1:0]     RD_DATA
);

  localparam int unsigned STEP       = BWIDTH / 8;
  localparam logic [2:0]  FULL_SIZE  = 3'($clog2(STEP));
  localparam logic [31:0] ALIGN_MASK = ~(ADDR_MASK | 32'(STEP - 1));

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [BWIDTH-1:0]     rdata_q, rdata_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [BWIDTH-1:0]     mask_q, mask_d;
  logic [BWIDTH-1:0]     wr_data_q, wr_data_d;
  logic                  last_rd_q, last_rd_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  err_q, err_d;

  logic                  ag_load_s, ag_step_s, ag_fixed_s, ag_last_s;
  logic [31:0]           ag_start_s, ag_addr_s;
  logic [3:0]            ag_len_s;
  logic [BWIDTH-1:0]     mask_s;
  logic                  unused_s;

  assign unused_s = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  axi2ram_addr_gen #(.STEP(STEP)) u_addr_gen (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (ag_load_s),
    .step_i  (ag_step_s),
    .addr_i  (ag_start_s),
    .len_i   (ag_len_s),
    .fixed_i (ag_fixed_s),
    .addr_o  (ag_addr_s),
    .last_o  (ag_last_s)
  );

  // Byte strobes widened into the RAM's per-bit write mask.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < int'(STEP); i++) begin
      mask_s[8*i +: 8] = {8{WSTRB[i]}};
    end
  end

  // Next-state and next-output logic; the READY pulse of the previous cycle marks the handshake.
  always_comb begin
    state_d    = state_q;
    awready_d  = 1'b0;
    arready_d  = 1'b0;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rid_d      = rid_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    rdata_d    = rdata_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wr_data_d  = wr_data_q;
    last_rd_d  = last_rd_q;
    id_d       = id_q;
    err_d      = err_q;
    ag_load_s  = 1'b0;
    ag_step_s  = 1'b0;
    ag_start_s = 32'd0;
    ag_len_s   = 4'd0;
    ag_fixed_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (awready_q) begin
          id_d       = AWID;
          err_d      = req_err(AWSIZE, AWBURST, FULL_SIZE);
          ag_load_s  = 1'b1;
          ag_start_s = AWADDR & ALIGN_MASK;
          ag_len_s   = AWLEN;
          ag_fixed_s = (AWBURST == BURST_FIXED);
          wready_d   = 1'b1;
          state_d    = S_WDATA;
        end else if (arready_q) begin
          id_d       = ARID;
          err_d      = req_err(ARSIZE, ARBURST, FULL_SIZE);
          ag_load_s  = 1'b1;
          ag_start_s = ARADDR & ALIGN_MASK;
          ag_len_s   = ARLEN;
          ag_fixed_s = (ARBURST == BURST_FIXED);
          state_d    = S_RADDR;
        end else if (AWVALID && (!ARVALID || last_rd_q)) begin
          awready_d  = 1'b1;
          last_rd_d  = 1'b0;
        end else if (ARVALID) begin
          arready_d  = 1'b1;
          last_rd_d  = 1'b1;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_WDATA: begin
        if (WVALID && wready_q) begin
          cs_d      = 1'b1;
          we_d      = 1'b1;
          addr_d    = ag_addr_s;
          mask_d    = mask_s;
          wr_data_d = WDATA;
          ag_step_s = 1'b1;
          if ((WLAST != ag_last_s) || (WID != id_q)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // The burst length, not WLAST, ends the write.
          if (ag_last_s) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_WRESP;
          end else begin
            state_d  = S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_WRESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_WRESP;
        end
      end
      S_RADDR: begin
        cs_d    = 1'b1;
        addr_d  = ag_addr_s;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = RD_DATA;
          rid_d    = id_q;
          rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
          rlast_d  = ag_last_s;
        end else if (RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d   = S_IDLE;
          end else begin
            ag_step_s = 1'b1;
            state_d   = S_RADDR;
          end
        end else begin
          state_d = S_RDATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight without a response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'd0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'd0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      mask_q    <= '0;
      wr_data_q <= '0;
      last_rd_q <= 1'b1;
      id_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      wr_data_q <= wr_data_d;
      last_rd_q <= last_rd_d;
      id_q      <= id_d;
      err_q     <= err_d;
    end
  end

  assign AWREADY = awready_q;
  assign ARREADY = arready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign RDATA   = rdata_q;
  assign CS      = cs_q;
  assign WE      = we_q;
  assign ADDR    = addr_q;
  assign MASK    = mask_q;
  assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_axi2ram.sv
// Directed bench for axi2ram: a RAM model, a transaction-level reference memory and a
// single negedge compare process checking every RAM access and every R beat.
module tb_axi2ram;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  AWID = 2'd0, WID = 2'd0, ARID = 2'd0, BID, RID;
  logic [31:0] AWADDR = 32'd0, ARADDR = 32'd0, ADDR;
  logic [3:0]  AWLEN = 4'd0, ARLEN = 4'd0, AWCACHE = 4'd0, ARCACHE = 4'd0;
  logic [2:0]  AWSIZE = 3'd0, ARSIZE = 3'd0, AWPROT = 3'd0, ARPROT = 3'd0;
  logic [1:0]  AWBURST = 2'd0, ARBURST = 2'd0, AWLOCK = 2'd0, ARLOCK = 2'd0, BRESP, RRESP;
  logic        AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID, CS, WE;
  logic [63:0] WDATA = 64'd0, RDATA, MASK, WR_DATA;
  logic [7:0]  WSTRB = 8'd0;
  logic [63:0] RD_DATA = 64'd0;

  axi2ram dut (
    .CLK(CLK), .RST(RST),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .WE(WE), .ADDR(ADDR), .MASK(MASK), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic we; logic [31:0] addr; logic [63:0] mask; logic [63:0] data; } ram_exp_t;
  typedef struct packed { logic [63:0] data; logic last; logic [1:0] id; logic [1:0] resp; } r_exp_t;

  ram_exp_t    ram_q[$];
  r_exp_t      r_q[$];
  logic [31:0] addr_log[$];
  logic [63:0] mask_log[$];
  logic [63:0] rdata_log[$];
  logic [63:0] mem [0:511];
  logic [63:0] ref_mem [0:511];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b1;
  time         aw_hs_t, ar_hs_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Beat b of a burst: FIXED stays put, anything else advances one 8-byte word per beat.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
    logic [31:0] base;
    base = a & ~32'd7;
    return (burst == 2'd0) ? base : base + 32'(8 * b);
  endfunction

  // Environment RAM: registered read data, masked writes.
  always @(posedge CLK) begin
    if (CS && WE) mem[ADDR[11:3]] <= (mem[ADDR[11:3]] & ~MASK) | (WR_DATA & MASK);
    else if (CS) RD_DATA <= mem[ADDR[11:3]];
  end

  // The compare process: every RAM access and every accepted R beat against the expectations.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (CS) begin
        addr_log.push_back(ADDR);
        mask_log.push_back(MASK);
        if (ram_q.size() == 0) begin
          check("ram_unexpected_cs", 64'(CS), 64'd0);
        end else begin
          ram_exp_t e;
          e = ram_q.pop_front();
          check("ram_we", 64'(WE), 64'(e.we));
          check("ram_addr", 64'(ADDR), 64'(e.addr));
          if (e.we) begin
            check("ram_mask", MASK, e.mask);
            check("ram_wdata", WR_DATA & e.mask, e.data & e.mask);
          end
        end
      end
      if (WE && !CS) check("we_without_cs", 64'(WE), 64'd0);
      if (RVALID && RREADY) begin
        rdata_log.push_back(RDATA);
        if (r_q.size() == 0) begin
          check("r_unexpected", 64'(RVALID), 64'd0);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          check("rdata", RDATA, e.data);
          check("rlast", 64'(RLAST), 64'(e.last));
          check("rid", 64'(RID), 64'(e.id));
          check("rresp", 64'(RRESP), 64'(e.resp));
        end
      end
    end
  end

  task automatic do_write(input logic [1:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                          input logic [63:0] d0, input int wlast_beat, input logic [1:0] exp_resp);
    bit ok;
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge CLK); ok = AWREADY; end
    check("aw_handshake_timeout", 64'(ok), 64'd1);
    @(posedge CLK); aw_hs_t = $time; #1 AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] ba;
      logic [63:0] m, d;
      ba = beat_addr(a, burst, b);
      m = strb_mask(strb);
      d = d0 + 64'(b);
      WVALID = 1'b1; WDATA = d; WSTRB = strb; WID = id;
      WLAST = (wlast_beat < 0) ? (b == int'(len)) : (b == wlast_beat);
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin @(negedge CLK); ok = WREADY; end
      check("w_handshake_timeout", 64'(ok), 64'd1);
      ram_q.push_back('{we: 1'b1, addr: ba, mask: m, data: d});
      ref_mem[ba[11:3]] = (ref_mem[ba[11:3]] & ~m) | (d & m);
      @(posedge CLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin @(negedge CLK); ok = BVALID; end
    check("b_timeout", 64'(ok), 64'd1);
    check("bresp", 64'(BRESP), 64'(exp_resp));
    check("bid", 64'(BID), 64'(id));
    @(posedge CLK); #1 BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                         input int stall_beat);
    bit ok;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge CLK); ok = ARREADY; end
    check("ar_handshake_timeout", 64'(ok), 64'd1);
    @(posedge CLK); ar_hs_t = $time; #1 ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      logic [31:0] ba;
      ba = beat_addr(a, burst, b);
      ram_q.push_back('{we: 1'b0, addr: ba, mask: 64'd0, data: 64'd0});
      r_q.push_back('{data: ref_mem[ba[11:3]], last: (b == int'(len)), id: id, resp: exp_resp});
    end
    for (int b = 0; b <= int'(len); b++) begin
      int lat;
      RREADY = (b != stall_beat);
      lat = 0;
      ok = 1'b0;
      while (!ok && lat < 20) begin @(posedge CLK); #1; lat++; ok = RVALID; end
      check("r_latency", 64'(lat), 64'd3);
      if (b == stall_beat) begin
        logic [63:0] held;
        held = RDATA;
        repeat (5) begin
          @(posedge CLK); #1;
          check("stall_rvalid", 64'(RVALID), 64'd1);
          check("stall_rdata", RDATA, held);
          check("stall_no_cs", 64'(CS), 64'd0);
        end
        RREADY = 1'b1;
      end
      @(posedge CLK); #1;
    end
    RREADY = 1'b0;
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 512; i++) begin mem[i] = 64'd0; ref_mem[i] = 64'd0; end
    #2;
    check("reset_outputs", 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RRESP,
                                RLAST, CS, WE} | {RDATA | MASK | WR_DATA} | 64'(ADDR)), 64'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    // Tie right after reset: write first, then read; a second tie goes to the write again.
    fork
      do_write(2'd2, 32'h400, 4'd0, 3'd3, 2'd1, 8'hFF, 64'hCAFE000000000001, -1, 2'd0);
      do_read (2'd3, 32'h400, 4'd0, 3'd3, 2'd1, 2'd0, -1);
    join
    check("tie1_write_first", 64'(aw_hs_t < ar_hs_t), 64'd1);
    fork
      do_write(2'd1, 32'h408, 4'd0, 3'd3, 2'd1, 8'hFF, 64'hCAFE000000000002, -1, 2'd0);
      do_read (2'd0, 32'h408, 4'd0, 3'd3, 2'd1, 2'd0, -1);
    join
    check("tie2_write_first", 64'(aw_hs_t < ar_hs_t), 64'd1);
    check("tie2_read_value", rdata_log[rdata_log.size()-1], 64'hCAFE000000000002);

    // Single write with a half-word strobe.
    addr_log.delete(); mask_log.delete();
    do_write(2'd1, 32'h100, 4'd0, 3'd3, 2'd1, 8'h0F, 64'h1122334455667788, -1, 2'd0);
    check("single_addr", 64'(addr_log[0]), 64'h100);
    check("single_mask", mask_log[0], 64'h00000000FFFFFFFF);
    check("single_cs_count", 64'(addr_log.size()), 64'd1);

    // INCR then FIXED bursts of four beats.
    addr_log.delete();
    do_write(2'd2, 32'h200, 4'd3, 3'd3, 2'd1, 8'hFF, 64'hA000000000000000, -1, 2'd0);
    check("incr_addr_seq", {addr_log[0][15:0], addr_log[1][15:0], addr_log[2][15:0], addr_log[3][15:0]},
          64'h0200_0208_0210_0218);
    addr_log.delete();
    do_write(2'd3, 32'h200, 4'd3, 3'd3, 2'd0, 8'hFF, 64'hB000000000000000, -1, 2'd0);
    check("fixed_addr_seq", {addr_log[0][15:0], addr_log[1][15:0], addr_log[2][15:0], addr_log[3][15:0]},
          64'h0200_0200_0200_0200);

    // Read bursts, plain and with a five-cycle stall on beat 2.
    rdata_log.delete();
    do_read(2'd1, 32'h200, 4'd3, 3'd3, 2'd1, 2'd0, -1);
    check("read_beat0_value", rdata_log[0], 64'hB000000000000003);
    check("read_beat1_value", rdata_log[1], 64'hA000000000000001);
    do_read(2'd2, 32'h200, 4'd3, 3'd3, 2'd1, 2'd0, 1);

    // Error responses.
    do_write(2'd0, 32'h300, 4'd0, 3'd2, 2'd1, 8'hFF, 64'h5555000000000000, -1, 2'd2);
    addr_log.delete();
    do_write(2'd1, 32'h320, 4'd3, 3'd3, 2'd1, 8'hFF, 64'h6666000000000000, 1, 2'd2);
    check("early_wlast_beats", 64'(addr_log.size()), 64'd4);
    do_read(2'd3, 32'h320, 4'd3, 3'd3, 2'd2, 2'd2, -1);

    // Reset during beat 2 of a read burst.
    mon_en = 1'b0;
    ARID = 2'd1; ARADDR = 32'h208; ARLEN = 4'd3; ARSIZE = 3'd3; ARBURST = 2'd1; ARVALID = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin @(negedge CLK); ok = ARREADY; end
    check("rst_ar_timeout", 64'(ok), 64'd1);
    @(posedge CLK); #1 ARVALID = 1'b0; RREADY = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(posedge CLK); #1; ok = RVALID; end
    check("rst_beat1_timeout", 64'(ok), 64'd1);
    @(posedge CLK); #1;
    @(posedge CLK); #3 RST = 1'b1;
    #1;
    check("rst_midburst_outputs", 64'({AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RID, RRESP,
                                       RLAST, CS, WE} | {RDATA | MASK | WR_DATA} | 64'(ADDR)), 64'd0);
    RREADY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    ram_q.delete(); r_q.delete(); rdata_log.delete();
    mon_en = 1'b1;
    do_read(2'd2, 32'h100, 4'd0, 3'd3, 2'd1, 2'd0, -1);
    check("post_reset_read", rdata_log.size() > 0 ? rdata_log[0] : 64'hX, 64'h0000000055667788);

    repeat (3) @(posedge CLK);
    check("ram_queue_drained", 64'(ram_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
